// File: rtl/iq_cordic_pkg.sv
// Shared types and constants for the I/Q to polar CORDIC.
// Angles are binary: 2^16 counts per full turn.
package iq_cordic_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ROT, SCALE, DONE} state_e;

  // 1/K for the CORDIC gain, Q15 (0.60725)
  localparam logic signed [16:0] K_INV = 17'sd19898;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/iq_polar_cordic_if.sv
// Sample-in / result-out handshake bundle of the polar CORDIC.
interface iq_polar_cordic_if #(
  parameter int DW = 14,
  parameter int PW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] I;
  logic signed [DW-1:0] Q;
  logic                 out_valid;
  logic                 out_ready;
  logic        [DW-1:0] mag;
  logic signed [PW-1:0] phase;
  logic                 busy;

  modport master (
    output in_valid, I, Q, out_ready,
    input  in_ready, out_valid, mag, phase, busy
  );

  modport slave (
    input  in_valid, I, Q, out_ready,
    output in_ready, out_valid, mag, phase, busy
  );
endinterface

// File: rtl/iq_cordic_microrotation.sv
// One vectoring-mode CORDIC micro-rotation: shift-add of X/Y, LUT step of Z.
module iq_cordic_microrotation
  import iq_cordic_pkg::*;
#(
  parameter int W  = 18,
  parameter int PW = 16
) (
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic        [PW-1:0] z_i,
  input  logic        [3:0]    idx_i,
  input  logic                 neg_i,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic        [PW-1:0] z_o
);
  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;
  logic        [PW-1:0] a;

  always_comb begin
    xs = x_i >>> idx_i;
    ys = y_i >>> idx_i;
    a  = PW'(atan_lut(idx_i));
    // Y negative: rotate counter-clockwise (d=+1), otherwise clockwise
    if (neg_i) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - a;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + a;
    end
  end
endmodule

// File: rtl/iq_polar_cordic.sv
// Iterative vectoring CORDIC: one signed (I,Q) sample in, gain-corrected
// magnitude and binary-angle phase out.
module iq_polar_cordic
  import iq_cordic_pkg::*;
#(
  parameter int DW   = 14,
  parameter int PW   = 16,
  parameter int ITER = 14,
  parameter int GB   = 2
) (
  input logic              CLK,
  input logic              reset,
  iq_polar_cordic_if.slave bus
);
  localparam int W = DW + 2 + GB;
  localparam int PRODW = W + 17;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic [PW-1:0] Z_QTR = PW'(1 << (PW - 2));
  localparam logic signed [PRODW-1:0] RND = PRODW'(1 << (14 + GB));

  state_e               state_q;
  logic signed [W-1:0]  x_q, y_q, x_in, y_in, rot_x, rot_y;
  logic        [PW-1:0] z_q, rot_z;
  logic        [3:0]    cnt_q;
  logic                 zero_q, in_ready_q, out_valid_q, busy_q;
  logic        [DW-1:0] mag_q, mag_d;
  logic        [PW-1:0] phase_q;
  logic signed [PRODW-1:0] prod, sh;

  assign x_in = $signed({{(W-DW){bus.I[DW-1]}}, bus.I}) <<< GB;
  assign y_in = $signed({{(W-DW){bus.Q[DW-1]}}, bus.Q}) <<< GB;

  iq_cordic_microrotation #(.W(W), .PW(PW)) u_rot (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .idx_i(cnt_q),
    .neg_i(y_q[W-1]),
    .x_o  (rot_x),
    .y_o  (rot_y),
    .z_o  (rot_z)
  );

  // Gain compensation with half-up rounding, clamped to [0, 2^DW-1]
  always_comb begin
    prod = PRODW'(x_q) * PRODW'(K_INV);
    sh   = (prod + RND) >>> (15 + GB);
    if (sh[PRODW-1])             mag_d = '0;
    else if (|sh[PRODW-2:DW])    mag_d = '1;
    else                         mag_d = sh[DW-1:0];
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mag_q       <= '0;
      phase_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            x_q        <= x_in;
            y_q        <= y_in;
            z_q        <= '0;
            cnt_q      <= '0;
            zero_q     <= (bus.I == '0) && (bus.Q == '0);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= PRE;
          end
        end
        PRE: begin
          // Fold left half-plane into the right so the rotations converge
          if (x_q[W-1]) begin
            if (!y_q[W-1]) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= Z_QTR;
            end else begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= -Z_QTR;
            end
          end
          cnt_q   <= '0;
          state_q <= ROT;
        end
        ROT: begin
          x_q <= rot_x;
          y_q <= rot_y;
          z_q <= rot_z;
          if (cnt_q == LAST) state_q <= SCALE;
          else               cnt_q   <= cnt_q + 4'd1;
        end
        SCALE: begin
          // Zero input has no defined angle; the rotations would still walk Z
          mag_q       <= mag_d;
          phase_q     <= zero_q ? '0 : z_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.mag       = mag_q;
  assign bus.phase     = $signed(phase_q);
endmodule

// File: tb/tb_iq_polar_cordic.sv
// Directed-vector bench for iq_polar_cordic: polar results, latency,
// result hold under back-pressure and mid-conversion reset.
module tb_iq_polar_cordic;
  localparam int DW = 14, PW = 16, ITER = 14, GB = 2;
  // Cycles from the accept cycle to the first cycle showing out_valid
  localparam int LAT = ITER + 3;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  iq_polar_cordic_if #(.DW(DW), .PW(PW)) bus ();

  iq_polar_cordic #(.DW(DW), .PW(PW), .ITER(ITER), .GB(GB)) u_dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int i;
    int q;
    int mag;
    int ph;
    int mtol;
    int ptol;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  // Phase compared on the circle, so +pi and -pi are neighbours
  task automatic chk_ph(input string name, input int act, input int exp, input int tol);
    logic signed [15:0] e16;
    int d;
    e16 = 16'(act - exp);
    d = int'(e16);
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  // Called at a negedge; returns at a negedge
  task automatic convert(input int i, input int q, input bit rel,
                         output int lat, output int m, output int p);
    int w;
    lat = 0;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge CLK);
      w++;
    end
    bus.I = DW'(i);
    bus.Q = DW'(q);
    bus.in_valid = 1'b1;
    while (lat < 60) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    m = int'(bus.mag);
    p = int'(bus.phase);
    if (rel) begin
      bus.out_ready = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, m, p;
    vecs[0] = '{4000, 0, 4000, 0, 2, 2};
    vecs[1] = '{0, 4000, 4000, 16384, 2, 2};
    vecs[2] = '{-4000, 0, 4000, -32768, 2, 2};
    vecs[3] = '{-8192, -8192, 11585, -24576, 3, 2};
    vecs[4] = '{0, 0, 0, 0, 0, 0};
    vecs[5] = '{3000, 4000, 5000, 9672, 3, 4};
    vecs[6] = '{0, -8192, 8192, -16384, 3, 4};
    vecs[7] = '{-3000, -4000, 5000, -23096, 3, 4};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.I = '0;
    bus.Q = '0;

    repeat (3) @(negedge CLK);
    chk("rst_in_ready", int'(bus.in_ready), 0, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_busy", int'(bus.busy), 0, 0);
    chk("rst_mag", int'(bus.mag), 0, 0);
    chk("rst_phase", int'(bus.phase), 0, 0);
    reset = 1'b0;
    @(negedge CLK);
    chk("idle_in_ready", int'(bus.in_ready), 1, 0);
    chk("idle_busy", int'(bus.busy), 0, 0);

    for (int k = 0; k < 8; k++) begin
      convert(vecs[k].i, vecs[k].q, 1'b1, lat, m, p);
      chk($sformatf("v%0d_latency", k), lat, LAT, 0);
      chk($sformatf("v%0d_mag", k), m, vecs[k].mag, vecs[k].mtol);
      chk_ph($sformatf("v%0d_phase", k), p, vecs[k].ph, vecs[k].ptol);
    end

    // Back-pressure: result held, new samples ignored
    convert(3000, 4000, 1'b0, lat, m, p);
    chk("hold_latency", lat, LAT, 0);
    for (int c = 0; c < 10; c++) begin
      bus.I = 14'sd100;
      bus.Q = 14'sd100;
      bus.in_valid = c[0];
      @(negedge CLK);
      chk($sformatf("hold%0d_out_valid", c), int'(bus.out_valid), 1, 0);
      chk($sformatf("hold%0d_in_ready", c), int'(bus.in_ready), 0, 0);
      chk($sformatf("hold%0d_mag", c), int'(bus.mag), 5000, 3);
      chk_ph($sformatf("hold%0d_phase", c), int'(bus.phase), 9672, 4);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("release_out_valid", int'(bus.out_valid), 0, 0);
    chk("release_in_ready", int'(bus.in_ready), 1, 0);
    chk("release_busy", int'(bus.busy), 0, 0);
    convert(0, 4000, 1'b1, lat, m, p);
    chk("after_hold_latency", lat, LAT, 0);
    chk_ph("after_hold_phase", p, 16384, 2);

    // Reset during ROT iteration 5
    bus.I = 14'sd4000;
    bus.Q = 14'sd0;
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("midrot_busy", int'(bus.busy), 1, 0);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0, 0);
    chk("abort_in_ready", int'(bus.in_ready), 0, 0);
    chk("abort_busy", int'(bus.busy), 0, 0);
    chk("abort_mag", int'(bus.mag), 0, 0);
    chk("abort_phase", int'(bus.phase), 0, 0);
    repeat (2) @(negedge CLK);
    chk("abort_hold_out_valid", int'(bus.out_valid), 0, 0);
    reset = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", int'(bus.in_ready), 1, 0);
    convert(-8192, -8192, 1'b1, lat, m, p);
    chk("post_rst_latency", lat, LAT, 0);
    chk("post_rst_mag", m, 11585, 3);
    chk_ph("post_rst_phase", p, -24576, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
